// File: rtl/scope_trigger_capture.sv
// scope_trigger_capture: re-frames the 20 kHz mic stream into FRAME_LEN-sample
// frames that begin PRETRIG samples before a level/slope trigger, with holdoff
// between frames. Optional macro SCOPE_TRIG_AUTO_EN adds an auto-trigger that
// fires after AUTO_TIMEOUT accepted samples in ARMED without a level trigger.
module scope_trigger_capture #(
   parameter int FRAME_LEN    = 1280,
   parameter int PRETRIG      = 64,
   parameter int HOLDOFF      = 256,
   parameter int HYST         = 8,
   parameter int AUTO_TIMEOUT = 4096
) (
   input  logic        i_clk_sample,
   input  logic        i_rst_n,
   input  logic        i_mic_valid,
   input  logic [11:0] i_mic_in,
   input  logic [9:0]  i_trig_level,
   input  logic        i_trig_slope,
   input  logic        i_hold,
   output logic [9:0]  o_wave_sample,
   output logic        o_wave_valid,
   output logic        o_frame_start,
   output logic        o_frame_done,
   output logic        o_armed,
   output logic        o_trig_auto
);
   localparam int MAXC = (FRAME_LEN > HOLDOFF) ? FRAME_LEN : HOLDOFF;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int PW   = (PRETRIG > 1) ? $clog2(PRETRIG) : 1;

   typedef enum logic [1:0] {S_FILL, S_ARMED, S_CAPTURE, S_HOLDOFF} state_t;

   state_t        r_state, w_state_nxt;
   logic [9:0]    r_dly [PRETRIG];
   logic [PW-1:0] r_wp;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_rearm, w_rearm_nxt;
   logic          r_slope_q;
   logic          w_emit, w_first, w_last, w_lvl, w_auto_hit, w_trig_auto_nxt;
   logic [9:0]    w_s, w_d, w_lo, w_hi;
   logic [10:0]   w_hi_sum;

   assign w_s      = i_mic_in[11:2];
   // Oldest entry at the write pointer is the sample from PRETRIG accepts ago.
   assign w_d      = r_dly[r_wp];
   // Hysteresis thresholds, saturated to the 10-bit sample range.
   assign w_lo     = ({1'b0, i_trig_level} >= 11'(HYST)) ? 10'(i_trig_level - 10'(HYST)) : 10'd0;
   assign w_hi_sum = {1'b0, i_trig_level} + 11'(HYST);
   assign w_hi     = (w_hi_sum > 11'd1023) ? 10'd1023 : w_hi_sum[9:0];
   // Level trigger uses the registered rearm so a same-sample set cannot fire.
   assign w_lvl    = r_rearm && (i_trig_slope ? (w_s <= i_trig_level) : (w_s >= i_trig_level));

`ifdef SCOPE_TRIG_AUTO_EN
   localparam int AW = $clog2(AUTO_TIMEOUT + 1);
   logic [AW-1:0] r_auto_cnt, w_auto_nxt;
   assign w_auto_hit = (int'(r_auto_cnt) + 1 >= AUTO_TIMEOUT);
`else
   assign w_auto_hit = 1'b0;
`endif

   // Delay line: written on every accepted sample regardless of state.
   always_ff @(posedge i_clk_sample) begin
      if (i_mic_valid) r_dly[r_wp] <= w_s;
   end

   // State register.
   always_ff @(posedge i_clk_sample or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_FILL;
      else          r_state <= w_state_nxt;
   end

   // Next-state, counter, rearm and output-strobe decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_rearm_nxt     = r_rearm;
      w_emit          = 1'b0;
      w_first         = 1'b0;
      w_last          = 1'b0;
      w_trig_auto_nxt = o_trig_auto;
`ifdef SCOPE_TRIG_AUTO_EN
      w_auto_nxt      = r_auto_cnt;
`endif
      case (r_state)
         S_FILL: if (i_mic_valid) begin
            if (int'(r_cnt) + 1 >= PRETRIG) begin
               w_state_nxt = S_ARMED;
               w_cnt_nxt   = '0;
               w_rearm_nxt = 1'b0;
`ifdef SCOPE_TRIG_AUTO_EN
               w_auto_nxt  = '0;
`endif
            end else w_cnt_nxt = r_cnt + 1'b1;
         end
         S_ARMED: begin
            // Slope change invalidates whatever rearm history was gathered.
            if (i_trig_slope != r_slope_q) w_rearm_nxt = 1'b0;
            else if (i_mic_valid && (i_trig_slope ? (w_s >= w_hi) : (w_s <= w_lo)))
               w_rearm_nxt = 1'b1;
            if (i_mic_valid) begin
`ifdef SCOPE_TRIG_AUTO_EN
               w_auto_nxt = r_auto_cnt + 1'b1;
`endif
               if (w_lvl || w_auto_hit) begin
                  w_state_nxt     = S_CAPTURE;
                  w_cnt_nxt       = CW'(1);
                  w_emit          = 1'b1;
                  w_first         = 1'b1;
                  w_trig_auto_nxt = !w_lvl;
               end
            end
         end
         S_CAPTURE: if (i_mic_valid) begin
            w_emit = 1'b1;
            if (int'(r_cnt) + 1 >= FRAME_LEN) begin
               w_last      = 1'b1;
               w_state_nxt = S_HOLDOFF;
               w_cnt_nxt   = '0;
            end else w_cnt_nxt = r_cnt + 1'b1;
         end
         S_HOLDOFF: if (i_mic_valid) begin
            if (int'(r_cnt) + 1 >= HOLDOFF) begin
               if (!i_hold) begin
                  w_state_nxt = S_ARMED;
                  w_cnt_nxt   = '0;
                  w_rearm_nxt = 1'b0;
`ifdef SCOPE_TRIG_AUTO_EN
                  w_auto_nxt  = '0;
`endif
               end else w_cnt_nxt = CW'(HOLDOFF);
            end else w_cnt_nxt = r_cnt + 1'b1;
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   // Datapath registers and registered outputs.
   always_ff @(posedge i_clk_sample or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wp          <= '0;
         r_cnt         <= '0;
         r_rearm       <= 1'b0;
         r_slope_q     <= 1'b0;
         o_wave_sample <= '0;
         o_wave_valid  <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_done  <= 1'b0;
         o_armed       <= 1'b0;
         o_trig_auto   <= 1'b0;
`ifdef SCOPE_TRIG_AUTO_EN
         r_auto_cnt    <= '0;
`endif
      end else begin
         if (i_mic_valid) r_wp <= (int'(r_wp) == PRETRIG - 1) ? '0 : r_wp + 1'b1;
         r_cnt         <= w_cnt_nxt;
         r_rearm       <= w_rearm_nxt;
         r_slope_q     <= i_trig_slope;
         if (w_emit) o_wave_sample <= w_d;
         o_wave_valid  <= w_emit;
         o_frame_start <= w_first;
         o_frame_done  <= w_last;
         o_armed       <= (w_state_nxt == S_ARMED);
         o_trig_auto   <= w_trig_auto_nxt;
`ifdef SCOPE_TRIG_AUTO_EN
         r_auto_cnt    <= w_auto_nxt;
`endif
      end
   end
endmodule
